// File: rtl/fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_scan_ctrl
// Multi-digit 7-segment (FND) scan controller for a common-anode display.
// Takes DIGITS packed hex nibbles plus per-digit decimal-point and blink masks.
// Time-multiplexes them onto the display, one digit per scan slot.
// Features:
//   - frame-coherent input snapshot, taken once per frame
//   - anti-ghosting dead time at the start of every slot
//   - per-digit blink
//   - scan enable
//
// Optional feature (compile-time macro FND_LZ_SUPPRESS_EN):
//   When defined, leading zeros are suppressed. Digits DIGITS-1..1 whose
//   nibble and all higher nibbles are zero show their segments off.
//   Digit 0 is never suppressed.
//
// Ports:
//   clk         in   1         system clock, rising edge
//   rst         in   1         asynchronous active-low reset (0 = reset)
//   en          in   1         1 = display on; 0 = all digits off, counters run
//   bcd         in   4*DIGITS  packed nibbles, [3:0] = digit 0 (rightmost)
//   dp_mask     in   DIGITS    1 = decimal point lit on that digit
//   blink_mask  in   DIGITS    1 = digit blanked during blink phase 1
//   fnd_data    out  8         active-low segments {dp,g,f,e,d,c,b,a}
//   fnd_com     out  DIGITS    active-low one-hot digit select
//   frame_tick  out  1         1-cycle pulse when a new snapshot is held
// -----------------------------------------------------------------------------
module fnd_scan_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int DIGITS   = 4,
    parameter int DEAD_CYC = 2,
    parameter int BLINK_HZ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7:0]            fnd_data,
    output logic [DIGITS-1:0]     fnd_com,
    output logic                  frame_tick
);

    localparam int TICK_DIV  = CLK_FREQ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Segment patterns for a..g, active low (dp handled separately).
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]       presc_q,        presc_d;
    logic [IW-1:0]       idx_q,          idx_d;
    logic [BW-1:0]       blink_cnt_q,    blink_cnt_d;
    logic                blink_ph_q,     blink_ph_d;
    logic [4*DIGITS-1:0] shadow_bcd_q,   shadow_bcd_d;
    logic [DIGITS-1:0]   shadow_dp_q,    shadow_dp_d;
    logic [DIGITS-1:0]   shadow_blink_q, shadow_blink_d;
    logic [7:0]          data_q,         data_d;
    logic [DIGITS-1:0]   com_q,          com_d;
    logic                tick_q,         tick_d;

    logic                presc_wrap;
    logic                blink_wrap;
    logic                snap;

    // -------------------------------------------------------------------------
    // Counters and snapshot
    // -------------------------------------------------------------------------
    always_comb begin
        presc_wrap  = (presc_q == PRESC_LAST);
        presc_d     = presc_wrap ? '0 : presc_q + 1'b1;

        idx_d = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        blink_wrap  = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q ^ blink_wrap;

        // The first cycle of slot 0 opens a new frame. This also covers the
        // first slot after reset, since the counters start there.
        snap           = (presc_q == '0) && (idx_q == '0);
        shadow_bcd_d   = snap ? bcd        : shadow_bcd_q;
        shadow_dp_d    = snap ? dp_mask    : shadow_dp_q;
        shadow_blink_d = snap ? blink_mask : shadow_blink_q;
        tick_d         = snap;
    end

    // -------------------------------------------------------------------------
    // Per-digit nibble view of the snapshot.
    // The _d side is used so the value captured this cycle is already visible.
    // This keeps a frame coherent even when there is no dead time.
    // -------------------------------------------------------------------------
    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] lz_blank;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = shadow_bcd_d[4*gi +: 4];
        end
    endgenerate

`ifdef FND_LZ_SUPPRESS_EN
    // Walk down from the top digit while nibbles stay zero. Digit 0 is excluded.
    always_comb begin
        logic run;
        run      = 1'b1;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run         = run & (nib[i] == 4'h0);
            lz_blank[i] = run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // -------------------------------------------------------------------------
    // Registered display outputs
    // -------------------------------------------------------------------------
    always_comb begin
        com_d  = '1;
        data_d = 8'hFF;
        if (en && (presc_q >= DEAD_END)) begin
            com_d[idx_q] = 1'b0;
            if (!(blink_ph_q && shadow_blink_d[idx_q])) begin
                data_d = {~shadow_dp_d[idx_q], seg7(nib[idx_q])};
                if (lz_blank[idx_q]) begin
                    data_d[6:0] = 7'h7F;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q        <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            blink_ph_q     <= 1'b0;
            shadow_bcd_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blink_q <= '0;
            data_q         <= 8'hFF;
            com_q          <= '1;
            tick_q         <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_ph_q     <= blink_ph_d;
            shadow_bcd_q   <= shadow_bcd_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blink_q <= shadow_blink_d;
            data_q         <= data_d;
            com_q          <= com_d;
            tick_q         <= tick_d;
        end
    end

    assign fnd_data   = data_q;
    assign fnd_com    = com_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_ctrl
// Randomized bench for fnd_scan_ctrl with a cycle-count reference model.
// Configuration: 4 digits, 10-cycle slots, 2 dead cycles, 20-cycle blink phase.
// Inputs applied for each cycle are recorded. The expected output after each
// clock edge is derived arithmetically from the cycle number since reset
// release, using the recorded inputs.
// -----------------------------------------------------------------------------
module tb_fnd_scan_ctrl;

    localparam int TICK  = 10;
    localparam int DIG   = 4;
    localparam int DEAD  = 2;
    localparam int PHASE = 20;
    localparam int FRAME = TICK * DIG;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [15:0] bcd = 16'h0;
    logic [3:0]  dp_mask    = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic [7:0]  fnd_data;
    logic [3:0]  fnd_com;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int phase_id = 0;
    int en_off_left = 0;

    logic [7:0]  seg_tab [16];
    logic [15:0] h_bcd [$];
    logic [3:0]  h_dp  [$];
    logic [3:0]  h_bl  [$];
    logic        h_en  [$];

    fnd_scan_ctrl #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (100),
        .DIGITS   (4),
        .DEAD_CYC (2),
        .BLINK_HZ (25)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd        (bcd),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .fnd_data   (fnd_data),
        .fnd_com    (fnd_com),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_inputs();
        h_bcd.push_back(bcd);
        h_dp.push_back(dp_mask);
        h_bl.push_back(blink_mask);
        h_en.push_back(en);
    endtask

    // Choose the inputs that will be present during cycle n.
    task automatic pick_inputs(input int n);
        if (phase_id == 0 && n < 80) begin
            // Plain scan of 1234, then a mid-frame change to 5678 during digit 2.
            bcd        = (n < 25) ? 16'h1234 : 16'h5678;
            dp_mask    = 4'h0;
            blink_mask = 4'h0;
            en         = 1'b1;
        end else if (phase_id == 0 && n < 200) begin
            // DP on digit 2, blink on digit 0, plus a 25-cycle display-off window.
            dp_mask    = 4'b0100;
            blink_mask = 4'b0001;
            en         = !(n >= 130 && n < 155);
            if ($urandom_range(0, 15) == 0) bcd = 16'($urandom);
        end else begin
            if ($urandom_range(0, 7) == 0)
                bcd = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) begin
                dp_mask    = 4'($urandom);
                blink_mask = 4'($urandom);
            end
            if (en_off_left > 0) begin
                en = 1'b0;
                en_off_left--;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 59) == 0) en_off_left = $urandom_range(1, 30);
            end
        end
    endtask

    // Compare the outputs seen after the n-th edge since reset release.
    task automatic check_cycle(input int n);
        int          t, p, d, ph, f0;
        logic [15:0] sb;
        logic [3:0]  sdp, sbl, nibv;
        logic [7:0]  exp_data;
        logic [3:0]  exp_com;
        logic        exp_tick;
        t  = n - 1;
        p  = t % TICK;
        d  = (t / TICK) % DIG;
        ph = (t / PHASE) % 2;
        f0 = (t / FRAME) * FRAME;
        sb  = h_bcd[f0];
        sdp = h_dp[f0];
        sbl = h_bl[f0];
        exp_tick = (t % FRAME) == 0;
        exp_com  = 4'hF;
        exp_data = 8'hFF;
        if (h_en[t] && p >= DEAD) begin
            exp_com[d] = 1'b0;
            if (!(ph == 1 && sbl[d])) begin
                nibv     = 4'((sb >> (4 * d)) & 16'hF);
                exp_data = seg_tab[nibv];
                exp_data[7] = ~sdp[d];
`ifdef FND_LZ_SUPPRESS_EN
                if (d > 0 && (sb >> (4 * d)) == 16'h0) exp_data[6:0] = 7'h7F;
`endif
            end
        end
        check_eq("fnd_com", 32'(fnd_com), 32'(exp_com));
        check_eq("fnd_data", 32'(fnd_data), 32'(exp_data));
        check_eq("frame_tick", 32'(frame_tick), 32'(exp_tick));
        check_eq("com_onehot", 32'($countones(~fnd_com) <= 1), 32'd1);
        if (exp_tick)
            $display("[TB] frame at cycle %0d: bcd=%04h dp=%b blink=%b", n, sb, sdp, sbl);
    endtask

    task automatic run_phase(input int cycles);
        h_bcd.delete();
        h_dp.delete();
        h_bl.delete();
        h_en.delete();
        en_off_left = 0;
        pick_inputs(0);
        push_inputs();
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clk);
            #1;
            check_cycle(n);
            pick_inputs(n);
            push_inputs();
        end
    endtask

    initial begin
        seg_tab[0]  = 8'hC0; seg_tab[1]  = 8'hF9; seg_tab[2]  = 8'hA4; seg_tab[3]  = 8'hB0;
        seg_tab[4]  = 8'h99; seg_tab[5]  = 8'h92; seg_tab[6]  = 8'h82; seg_tab[7]  = 8'hF8;
        seg_tab[8]  = 8'h80; seg_tab[9]  = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
        seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;

        // Power-on reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_com", 32'(fnd_com), 32'hF);
        check_eq("rst_data", 32'(fnd_data), 32'hFF);
        check_eq("rst_tick", 32'(frame_tick), 32'h0);

        phase_id = 0;
        run_phase(403);

        // Mid-slot reset: outputs go dark within the same cycle.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("midrst_com", 32'(fnd_com), 32'hF);
        check_eq("midrst_data", 32'(fnd_data), 32'hFF);
        check_eq("midrst_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(posedge clk);

        phase_id = 1;
        run_phase(1600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
